// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | traffic_phase_sequencer                                                |
// | Two-road phase controller: green/yellow/all-red sequencing, pedestrian |
// | green shortening and night flashing-yellow mode, advanced on a tick.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module traffic_phase_sequencer #(
   parameter int T_GREEN  = 10,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 2,
   parameter int T_SHORT  = 3,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             ped_req,
   input  logic             night_en,
   output logic [5:0]       light_n,
   output logic [CNT_W-1:0] remain,
   output logic [2:0]       phase,
   output logic             ped_ack
);

   typedef enum logic [2:0] {
      S_NS_G  = 3'd0,
      S_NS_Y  = 3'd1,
      S_AR_A  = 3'd2,
      S_EW_G  = 3'd3,
      S_EW_Y  = 3'd4,
      S_AR_B  = 3'd5,
      S_NIGHT = 3'd6,
      S_BAD   = 3'd7
   } phase_t;

   localparam logic [CNT_W-1:0] c_GREEN  = CNT_W'(T_GREEN);
   localparam logic [CNT_W-1:0] c_YELLOW = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] c_ALLRED = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] c_SHORT  = CNT_W'(T_SHORT);
   localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

   phase_t           r_phase, w_phase_nx;
   logic [CNT_W-1:0] r_remain, w_remain_nx;
   logic [5:0]       r_light_n, w_light_nx;
   logic             r_blink, w_blink_nx;
   logic             r_ped_pending, w_pend_nx;
   logic             r_ped_ack, w_ack_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase       <= S_AR_B;
         r_remain      <= c_ALLRED;
         r_light_n     <= 6'b011011;
         r_blink       <= 1'b0;
         r_ped_pending <= 1'b0;
         r_ped_ack     <= 1'b0;
      end else begin
         r_phase       <= w_phase_nx;
         r_remain      <= w_remain_nx;
         r_light_n     <= w_light_nx;
         r_blink       <= w_blink_nx;
         r_ped_pending <= w_pend_nx;
         r_ped_ack     <= w_ack_nx;
      end
   end

   always_comb begin
      w_phase_nx  = r_phase;
      w_remain_nx = r_remain;
      w_blink_nx  = r_blink;
      w_pend_nx   = r_ped_pending | ped_req;
      w_ack_nx    = 1'b0;

      if (r_phase == S_BAD) begin
         // Corrupted state recovers immediately, without waiting for a tick.
         w_phase_nx  = S_AR_B;
         w_remain_nx = c_ALLRED;
         w_blink_nx  = 1'b0;
      end else if (r_phase == S_NIGHT) begin
         if (tick) begin
            w_blink_nx = ~r_blink;
            if (!night_en) begin
               w_phase_nx  = S_AR_B;
               w_remain_nx = c_ALLRED;
               w_blink_nx  = 1'b0;
            end
         end
      end else if (tick) begin
         // A request arriving on the servicing edge stays pending for later.
         if ((r_phase == S_NS_G || r_phase == S_EW_G) && r_ped_pending) begin
            w_ack_nx  = 1'b1;
            w_pend_nx = ped_req;
         end
         if (w_ack_nx && (r_remain > c_SHORT)) begin
            w_remain_nx = c_SHORT;
         end else if (r_remain > c_ONE) begin
            w_remain_nx = r_remain - c_ONE;
         end else begin
            unique case (r_phase)
               S_NS_G: begin w_phase_nx = S_NS_Y; w_remain_nx = c_YELLOW; end
               S_NS_Y: begin w_phase_nx = S_AR_A; w_remain_nx = c_ALLRED; end
               S_EW_G: begin w_phase_nx = S_EW_Y; w_remain_nx = c_YELLOW; end
               S_EW_Y: begin w_phase_nx = S_AR_B; w_remain_nx = c_ALLRED; end
               S_AR_A, S_AR_B: begin
                  if (night_en) begin
                     w_phase_nx  = S_NIGHT;
                     w_remain_nx = '0;
                     w_blink_nx  = 1'b1;
                  end else begin
                     w_phase_nx  = (r_phase == S_AR_A) ? S_EW_G : S_NS_G;
                     w_remain_nx = c_GREEN;
                  end
               end
               default: begin w_phase_nx = S_AR_B; w_remain_nx = c_ALLRED; end
            endcase
         end
      end
   end

   always_comb begin
      w_light_nx = 6'b011011;
      unique case (w_phase_nx)
         S_NS_G:  w_light_nx = 6'b110011;
         S_NS_Y:  w_light_nx = 6'b101011;
         S_EW_G:  w_light_nx = 6'b011110;
         S_EW_Y:  w_light_nx = 6'b011101;
         S_NIGHT: w_light_nx = w_blink_nx ? 6'b101101 : 6'b111111;
         default: w_light_nx = 6'b011011;
      endcase
   end

   assign light_n = r_light_n;
   assign remain  = r_remain;
   assign phase   = r_phase;
   assign ped_ack = r_ped_ack;

endmodule
`default_nettype wire

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Phase controller for a two-road intersection (NS / EW). It sequences green, yellow and all-red clearance, shortens green on pedestrian request, and supports a night flashing-yellow mode.
- Runs on the system clock and advances on a single-cycle 1 Hz `tick` enable from the existing clock divider.
- Drives the active-low 6-bit lamp bus and a seconds-remaining value for the countdown display.

Parameters:
- T_GREEN, 10, green duration in ticks (2..2^CNT_W-1)
- T_YELLOW, 3, yellow duration in ticks (1..2^CNT_W-1)
- T_ALLRED, 2, all-red clearance duration in ticks (1..2^CNT_W-1)
- T_SHORT, 3, green time left after a pedestrian request (1..T_GREEN-1)
- CNT_W, 5, width of remaining-time counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  one-clk-wide 1 Hz advance enable
- ped_req  in  1  pedestrian request pulse; level is also accepted
- night_en  in  1  request night flashing mode (level)
- light_n  out  6  lamps, 0 = lit: [5]ns_r [4]ns_y [3]ns_g [2]ew_r [1]ew_y [0]ew_g
- remain  out  CNT_W  ticks left in current phase
- phase  out  3  current phase code
- ped_ack  out  1  one-clk pulse when a pending request is serviced

Behaviour:
- Clock, reset and register timing:
  - One clock domain; reset is synchronous, active-low, named rst_n; clock named clk.
  - Every output is a register.
  - State changes only on a clk edge where tick=1. Outputs reflect the change in the same edge, so latency is 1 clk after tick is sampled.
- Reset (rst_n=0 at a clk edge; tick ignored):
  - phase=AR_B(5), remain=T_ALLRED, light_n=6'b011011.
  - ped_pending=0, ped_ack=0, blink=0.
- Phase codes and lamps:
  - 0 NS_G 110011
  - 1 NS_Y 101011
  - 2 AR_A 011011
  - 3 EW_G 011110
  - 4 EW_Y 011101
  - 5 AR_B 011011
  - 6 NIGHT 101101 (blink=1) or 111111 (blink=0)
  - Codes 7 and above are illegal: recover to AR_B with remain=T_ALLRED on the next clk, tick not required.
- Normal sequence: NS_G -> NS_Y -> AR_A -> EW_G -> EW_Y -> AR_B -> NS_G.
- Countdown rule (non-night phases):
  - On tick with remain>1: remain decrements.
  - On tick with remain==1: move to the next phase and load its duration (T_GREEN / T_YELLOW / T_ALLRED).
  - Each phase therefore lasts exactly its parameter in ticks, and remain displays N..1.
- Pedestrian request:
  - ped_req=1 on any clk sets ped_pending; set has priority over clear in the same clk.
  - Servicing happens on a tick while in NS_G or EW_G with ped_pending=1:
    - If remain>T_SHORT: remain loads T_SHORT instead of decrementing.
    - Otherwise the normal countdown/transition rule applies.
    - In either case ped_pending clears and ped_ack pulses for 1 clk.
  - Requests arriving in yellow, all-red or night stay pending until the next green tick.
- Night mode:
  - night_en is sampled only at the AR_A->EW_G and AR_B->NS_G boundaries. If night_en=1 there, enter NIGHT instead, with remain=0 and blink=1.
  - In NIGHT, each tick toggles blink. ped_req still latches but is not serviced.
  - On a tick in NIGHT with night_en=0: go to AR_B, remain=T_ALLRED; the normal sequence then resumes at NS_G.
- Simultaneous events:
  - tick plus ped_req on the same clk: the request is latched; servicing waits for a later tick.
  - Reset overrides everything, including mid-phase and mid-night.
- Width: remain is CNT_W bits unsigned. Parameters exceeding 2^CNT_W-1 are illegal and are not checked in RTL.

Test Plan:
- Reset then 30 ticks, night_en=0, ped_req=0:
  - AR_B for 2 ticks, NS_G 10, NS_Y 3, AR_A 2, EW_G 10, then EW_Y.
  - light_n and phase match the table.
  - remain follows 2,1,10..1,3..1,...
- ped_req pulse during NS_G at remain=8 -> next tick remain=3, ped_ack 1-clk pulse, then NS_Y after 3 more ticks.
- ped_req during NS_G at remain=2 -> next tick remain=1 (normal decrement), ped_ack pulses. A second request during NS_Y is held and serviced at the first EW_G tick (remain 10->3).
- night_en=1 asserted during EW_G:
  - No effect until AR_B completes; then phase=6, light_n alternates 101101 / 111111 per tick.
  - Deassert -> AR_B for 2 ticks, then NS_G.
- rst_n=0 for 1 clk mid EW_G with ped_pending=1 -> next clk phase=5, remain=2, light_n=011011, pending cleared, no ped_ack.
- tick held 0 for 1000 clks in any phase -> all outputs stable; tick pulse width strictly 1 clk per advance.
